// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple stage reused over NIBBLES cycles.
// A registered carry chains each nibble to the next; result is registered.

module nibble_rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 ci,
  output logic                 ready,
  output logic                 busy,
  output logic                 valid,
  output logic [4*NIBBLES-1:0] s,
  output logic                 co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx;
  logic          cr;
  logic [W-1:0]  ash;
  logic [W-1:0]  bsh;
  logic [W-1:0]  acc;

  logic          load;
  logic          step;
  logic          last;
  logic [3:0]    ns;
  logic          nc;
  logic [W+3:0]  cat;
  logic [W-1:0]  nacc;

  nibble_rca u_rca (
    .a  (ash[3:0]),
    .b  (bsh[3:0]),
    .ci (cr),
    .s  (ns),
    .co (nc)
  );

  // New nibble enters at the top; after NIBBLES steps nibble 0 sits at the bottom.
  assign cat  = {ns, acc};
  assign nacc = cat[W+3:4];
  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      cr      <= 1'b0;
      ash     <= '0;
      bsh     <= '0;
      acc     <= '0;
      s       <= '0;
      co      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ash <= a;
        bsh <= b;
        cr  <= ci;
        idx <= '0;
      end else if (step) begin
        ash <= ash >> 4;
        bsh <= bsh >> 4;
        cr  <= nc;
        acc <= nacc;
        idx <= last ? '0 : idx + IW'(1);
        if (last) begin
          s  <= nacc;
          co <= nc;
        end
      end
    end
  end

  assign ready = (state_q != RUN);
  assign busy  = (state_q == RUN);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at NIBBLES = 4, 1 and 8.
// Expected sums are hand-computed constants or a+b+ci in the bench.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  logic        st4, ci4, rdy4, bsy4, vld4, co4;
  logic [15:0] a4, b4, s4;
  logic        st1, ci1, rdy1, bsy1, vld1, co1;
  logic [3:0]  a1, b1, s1;
  logic        st8, ci8, rdy8, bsy8, vld8, co8;
  logic [31:0] a8, b8, s8;

  nibble_serial_adder #(.NIBBLES(4)) d4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .ci(ci4),
    .ready(rdy4), .busy(bsy4), .valid(vld4), .s(s4), .co(co4)
  );

  nibble_serial_adder #(.NIBBLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .ci(ci1),
    .ready(rdy1), .busy(bsy1), .valid(vld1), .s(s1), .co(co1)
  );

  nibble_serial_adder #(.NIBBLES(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .ci(ci8),
    .ready(rdy8), .busy(bsy8), .valid(vld8), .s(s8), .co(co8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    ntot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic run4(input string tag, input logic [15:0] x,
                      input logic [15:0] y, input logic c);
    logic [16:0] e;
    int n;
    e   = {1'b0, x} + {1'b0, y} + {16'd0, c};
    a4  = x;
    b4  = y;
    ci4 = c;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    n   = 0;
    while (!vld4 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {46'd0, vld4, co4, s4}, {46'd0, 1'b1, e});
    tick();
  endtask

  task automatic run8(input string tag, input logic [31:0] x,
                      input logic [31:0] y, input logic c);
    logic [32:0] e;
    int n;
    e   = {1'b0, x} + {1'b0, y} + {32'd0, c};
    a8  = x;
    b8  = y;
    ci8 = c;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    n   = 0;
    while (!vld8 && n < 30) begin
      tick();
      n++;
    end
    check(tag, {30'd0, vld8, co8, s8}, {30'd0, 1'b1, e});
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    st4 = 0; a4 = '0; b4 = '0; ci4 = 0;
    st1 = 0; a1 = '0; b1 = '0; ci1 = 0;
    st8 = 0; a8 = '0; b8 = '0; ci8 = 0;

    // reset, then idle
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("idle4", {rdy4, bsy4, vld4, co4, s4}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
      tick();
    end
    check("idle1", {rdy1, bsy1, vld1, co1, s1}, {4'b1000, 4'h0});
    check("idle8", {rdy8, bsy8, vld8, co8, s8}, {4'b1000, 32'h0});

    // full carry ripple
    st4 = 1'b1; a4 = 16'hFFFF; b4 = 16'h0001; ci4 = 1'b0;
    tick();
    st4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("ripple_run", {bsy4, rdy4, vld4}, 3'b100);
      tick();
    end
    check("ripple_valid", {vld4, rdy4, bsy4, co4, s4}, {4'b1101, 16'h0000});
    tick();
    check("ripple_idle", {vld4, rdy4}, 2'b01);

    // carry-in; inputs and start wiggled during RUN
    st4 = 1'b1; a4 = 16'h1234; b4 = 16'h4321; ci4 = 1'b1;
    tick();
    a4 = 16'hAAAA; b4 = 16'hAAAA; ci4 = 1'b0;
    tick();
    tick();
    tick();
    st4 = 1'b0;
    check("cin_busy", {bsy4, rdy4}, 2'b10);
    tick();
    check("cin_valid", {vld4, co4, s4}, {2'b10, 16'h5556});
    tick();
    check("cin_idle", {vld4, s4}, {1'b0, 16'h5556});

    // back-to-back with start held high
    st4 = 1'b1; a4 = 16'h00FF; b4 = 16'h0F01; ci4 = 1'b0;
    tick();
    a4 = 16'h8000; b4 = 16'h8000; ci4 = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    check("b2b_v1", {vld4, rdy4, co4, s4}, {3'b110, 16'h1000});
    tick();
    for (int c = 6; c <= 9; c++) begin
      check("b2b_hold", {vld4, bsy4, co4, s4}, {3'b010, 16'h1000});
      tick();
    end
    check("b2b_v2", {vld4, co4, s4}, {2'b11, 16'h0001});
    st4 = 1'b0;
    tick();
    check("b2b_idle", {vld4, rdy4}, 2'b01);

    // reset in the middle of an operation
    st4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF; ci4 = 1'b0;
    tick();
    st4 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_state", {bsy4, rdy4, vld4, co4, s4}, {4'b0100, 16'h0});
    for (int i = 0; i < 6; i++) begin
      check("abort_novalid", {vld4, bsy4}, 2'b00);
      tick();
    end
    run4("after_abort", 16'h0001, 16'h0001, 1'b0);
    check("after_abort_s", s4, 16'h0002);

    // single-nibble instance
    st1 = 1'b1; a1 = 4'hF; b1 = 4'h1; ci1 = 1'b1;
    tick();
    st1 = 1'b0;
    check("n1_run", {bsy1, vld1}, 2'b10);
    tick();
    check("n1_valid", {vld1, co1, s1}, {2'b11, 4'h1});
    tick();

    // random sweeps against a+b+ci
    for (int i = 0; i < 1000; i++)
      run4("rnd4", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1000; i++)
      run8("rnd8", $urandom, $urandom, 1'($urandom_range(0, 1)));
    run8("max8", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
